// File: rtl/mc14500b_loader_pkg.sv
// rtl/mc14500b_loader_pkg.sv - shared types for the MC14500B program loader
package mc14500b_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/mc14500b_loader.sv
// rtl/mc14500b_loader.sv - streams program words into text RAM and gates the MC14500B core
module mc14500b_loader
    import mc14500b_loader_pkg::*;
#(
    parameter int ADDR = 8,
    parameter int CODE = 4,
    parameter int WORD = ADDR + CODE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_load,
    input  logic            run_req,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] in_data,
    input  logic            in_last,
    input  logic            flag_f,
    output logic            prog_write,
    output logic [ADDR-1:0] prog_addr,
    output logic [WORD-1:0] prog_cmd,
    output logic            prog_sel,
    output logic            cpu_rst,
    output logic [ADDR:0]   word_count,
    output logic            overflow,
    output logic [1:0]      state
);

    localparam logic [ADDR:0]   WC_MAX   = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR-1:0] ADDR_TOP = {ADDR{1'b1}};

    loader_state_t   state_q;
    logic [ADDR-1:0] addr_q;
    // Set by the final transfer: hold LOAD one more cycle so the last write
    // lands while the core is still in reset.
    logic            run_pend;

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            run_pend   <= 1'b0;
            in_ready   <= 1'b0;
            prog_write <= 1'b0;
            prog_addr  <= '0;
            prog_cmd   <= '0;
            prog_sel   <= 1'b0;
            cpu_rst    <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prog_write <= 1'b0;
            if (start_load && state_q != LOAD) begin
                state_q    <= LOAD;
                addr_q     <= '0;
                run_pend   <= 1'b0;
                in_ready   <= 1'b1;
                prog_sel   <= 1'b1;
                cpu_rst    <= 1'b1;
                word_count <= '0;
                overflow   <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (run_pend) begin
                            state_q  <= RUN;
                            run_pend <= 1'b0;
                            cpu_rst  <= 1'b0;
                            prog_sel <= 1'b0;
                        end else if (in_valid && in_ready) begin
                            prog_write <= 1'b1;
                            prog_addr  <= addr_q;
                            prog_cmd   <= in_data;
                            if (word_count != WC_MAX)
                                word_count <= word_count + 1'b1;
                            if (in_last) begin
                                run_pend <= 1'b1;
                                in_ready <= 1'b0;
                            end else if (addr_q == ADDR_TOP) begin
                                overflow <= 1'b1;
                                state_q  <= IDLE;
                                in_ready <= 1'b0;
                                prog_sel <= 1'b0;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (flag_f) begin
                            state_q <= HALT;
                            cpu_rst <= 1'b1;
                        end
                    end
                    HALT: begin
                        if (run_req) begin
                            state_q <= RUN;
                            cpu_rst <= 1'b0;
                        end
                    end
                    default: begin
                        cpu_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
